if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline, directly upstream of the D-stage decoder.
- Holds the PC, drives the instruction-memory address, and computes the next PC from D-stage redirect info (j/jal, beq/blt, jr/jalr).
- Holds the IF/ID pipeline register that feeds the decoder.
- Architectural branch delay slot: the instruction after a jump/branch always executes.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_WORDS, 4096, instruction-memory depth in words; legal fetch window is [PC_RESET, PC_RESET+4*IM_WORDS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  from hazard unit; freeze PC and IF/ID
- redirect  in  1  D-stage instruction is a taken control transfer (jump, or branch with compare true)
- npc_sel  in  2  target kind: 0 = j/jal imm26, 1 = branch imm16, 2 = jr/jalr register, 3 = reserved
- imm26_D  in  26  jump field of D instruction
- imm16_D  in  16  branch offset of D instruction
- jr_target  in  32  forwarded rs value for jr/jalr
- imem_addr  out  32  current fetch PC (PC_F)
- imem_instr  in  32  combinational instruction-memory read data for imem_addr
- instr_D  out  32  IF/ID instruction to decoder
- pc_D  out  32  PC of instr_D
- pc8_D  out  32  pc_D+8, link value for jal/jalr
- fetch_fault  out  1  sticky: an out-of-window or misaligned PC was fetched

Behaviour:
- Reset (reset=0, asynchronous):
  - PC_F=PC_RESET; instr_D=32'h0 (nop); pc_D=PC_RESET; fetch_fault=0.
  - Takes effect immediately, including mid-redirect or mid-stall.
  - First instruction reaches instr_D one clock edge after reset deasserts.
- Fetched word:
  - Fetch is legal when PC_F[1:0]==0 and PC_F is inside the legal window.
  - Legal fetch: fetched word = imem_instr.
  - Otherwise: fetched word = 32'h0 (nop), and fetch_fault is set on the next unstalled edge.
  - fetch_fault clears only on reset.
- Targets (combinational, 32-bit wrap-around, no overflow detection):
  - sel 0: {pc_D[31:28], imm26_D, 2'b00}
  - sel 1: pc_D + 4 + (sign_extend(imm16_D) << 2)
  - sel 2: jr_target, used unaligned as-is; the fault is caught at fetch.
  - sel 3: PC_F + 4 (treated as no redirect).
- Per rising edge, priority order:
  1. stall=1: PC_F, instr_D and pc_D all hold; redirect is ignored this cycle. The stalled D instruction re-presents redirect on the next cycle.
  2. stall=0, redirect=1: PC_F <= target; instr_D <= fetched word (the delay slot, not squashed); pc_D <= PC_F.
  3. Otherwise: PC_F <= PC_F+4; instr_D <= fetched word; pc_D <= PC_F.
- Latency:
  - Redirect target is fetched on the cycle after redirect is sampled.
  - A target instruction enters D two edges after its branch was in D, with exactly one delay-slot instruction in between.
- Outputs:
  - pc8_D = pc_D + 8, purely combinational.
  - imem_addr = PC_F at all times, including while stalled.
- Back-to-back redirects: a jump sitting in the delay slot is honoured normally on the following cycle. No special casing.

Decomposition:
- Shared package mips_pkg:
  - PC_RESET and IM_WORDS defaults.
  - NPC_SEL_J=0, NPC_SEL_BR=1, NPC_SEL_JR=2 (also used by the decoder's typeJB output).
  - NOP=32'h0.
- One sub-module, npc_calc: combinational target mux plus PC+4 adder. PC and IF/ID registers stay in the top.

Test Plan:
- Reset, then 3 free-running cycles, imem returns 0x3402_0001 / 0x3403_0002 / 0x0000_0000:
  - imem_addr = 0x3000, 0x3004, 0x3008.
  - instr_D follows one cycle later; pc8_D = 0x3008 when pc_D = 0x3000.
- Jal at pc_D=0x3004, imm26=0x0000C10, redirect=1, sel=0:
  - Delay slot from 0x3008 enters D next.
  - PC_F becomes 0x0000_3040; the instruction at 0x3040 is in D two edges later.
- Beq at pc_D=0x3010 with imm16=0xFFFC, sel=1, redirect=1:
  - Target is 0x3004; delay slot at 0x3014 is still delivered to D.
- stall=1 for 2 cycles with redirect=1 asserted:
  - PC_F, instr_D and pc_D are unchanged both cycles.
  - On release, the redirect is taken exactly once.
- jr with jr_target=0x0000_1000 (below window):
  - Fetched word is a nop and fetch_fault=1 after the edge; the flag stays 1 until reset.
  - Repeat with jr_target=0x3002 (misaligned): same result.
- Assert reset low mid-cycle during a redirect:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - After release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset PC, instruction-memory geometry,
// next-PC select encodings and the fetch-window legality check.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEFAULT = 4096;

    // Also driven by the decoder's typeJB output.
    localparam logic [1:0] NPC_SEL_J  = 2'd0;
    localparam logic [1:0] NPC_SEL_BR = 2'd1;
    localparam logic [1:0] NPC_SEL_JR = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Word-aligned and inside [base, base + 4*words); 33-bit compare so the
    // upper bound cannot wrap.
    function automatic logic fetch_legal(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input int unsigned words);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] pc_ext;
        lo     = {1'b0, base};
        hi     = lo + (33'(words) << 2);
        pc_ext = {1'b0, pc};
        return (pc[1:0] == 2'b00) && (pc_ext >= lo) && (pc_ext < hi);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC computation: PC+4 adder and redirect target mux for j/jal,
// beq/blt and jr/jalr.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    input  logic        redirect_i,
    input  logic [1:0]  npc_sel_i,
    input  logic [25:0] imm26_i,
    input  logic [15:0] imm16_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] npc_o
);

    logic [31:0] br_target;
    logic [31:0] target;

    always_comb begin
        pc_plus4_o = pc_f_i + 32'd4;
        br_target  = pc_d_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
        target     = pc_plus4_o;
        unique case (npc_sel_i)
            NPC_SEL_J:  target = {pc_d_i[31:28], imm26_i, 2'b00};
            NPC_SEL_BR: target = br_target;
            // Unaligned jr targets pass through; the fetch check flags them.
            NPC_SEL_JR: target = jr_target_i;
            default:    target = pc_plus4_o;
        endcase
        npc_o = redirect_i ? target : pc_plus4_o;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, instruction fetch with window/alignment check,
// sticky fetch fault and the IF/ID pipeline register feeding the decoder.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  npc_sel,
    input  logic [25:0] imm26_D,
    input  logic [15:0] imm16_D,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        fetch_fault
);

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        legal;
    logic [31:0] fetched;

    npc_calc u_npc_calc (
        .pc_f_i      (pc_f_q),
        .pc_d_i      (pc_d_q),
        .redirect_i  (redirect),
        .npc_sel_i   (npc_sel),
        .imm26_i     (imm26_D),
        .imm16_i     (imm16_D),
        .jr_target_i (jr_target),
        .pc_plus4_o  (pc_plus4),
        .npc_o       (npc)
    );

    always_comb begin
        legal   = fetch_legal(pc_f_q, PC_RESET, IM_WORDS);
        fetched = legal ? imem_instr : NOP;

        pc_f_d    = pc_f_q;
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        fault_d   = fault_q;
        // A stall also drops any redirect; the held D instruction re-presents it.
        if (!stall) begin
            pc_f_d    = npc;
            instr_d_d = fetched;
            pc_d_d    = pc_f_q;
            fault_d   = fault_q | ~legal;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f_q    <= PC_RESET;
            instr_d_q <= NOP;
            pc_d_q    <= PC_RESET;
            fault_q   <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_addr   = pc_f_q;
    assign instr_D     = instr_d_q;
    assign pc_D        = pc_d_q;
    assign pc8_D       = pc_d_q + 32'd8;
    assign fetch_fault = fault_q;

    logic unused_pc_plus4;
    assign unused_pc_plus4 = ^pc_plus4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequencing, redirects, stall, faults and
// asynchronous reset, against hand-computed expected values.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [1:0]  npc_sel;
    logic [25:0] imm26_D;
    logic [15:0] imm16_D;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .npc_sel     (npc_sel),
        .imm26_D     (imm26_D),
        .imm16_D     (imm16_D),
        .jr_target   (jr_target),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .pc8_D       (pc8_D),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Program image: three fixed words at the reset PC, a tagged word elsewhere.
    always_comb begin
        unique case (imem_addr)
            32'h0000_3000: imem_instr = 32'h3402_0001;
            32'h0000_3004: imem_instr = 32'h3403_0002;
            32'h0000_3008: imem_instr = 32'h0000_0000;
            default:       imem_instr = {16'hC0DE, imem_addr[15:0]};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pcf,
                                input logic [31:0] ins, input logic [31:0] pcd,
                                input logic flt);
        check({tag, ".pcf"},   imem_addr, pcf);
        check({tag, ".instr"}, instr_D, ins);
        check({tag, ".pcd"},   pc_D, pcd);
        check({tag, ".pc8"},   pc8_D, pcd + 32'd8);
        check({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, flt});
    endtask

    task automatic drive(input logic rd, input logic [1:0] sel, input logic [25:0] i26,
                         input logic [15:0] i16, input logic [31:0] jr);
        redirect  = rd;
        npc_sel   = sel;
        imm26_D   = i26;
        imm16_D   = i16;
        jr_target = jr;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        #12;
        expect_state("rst", 32'h3000, 32'h0, 32'h3000, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Free-running fetch.
        tick(); expect_state("seq1", 32'h3004, 32'h3402_0001, 32'h3000, 1'b0);
        tick(); expect_state("seq2", 32'h3008, 32'h3403_0002, 32'h3004, 1'b0);

        // jal at 0x3004 -> 0x3040, delay slot 0x3008 next.
        drive(1'b1, 2'd0, 26'h000_0C10, 16'd0, 32'd0);
        tick(); expect_state("jal", 32'h3040, 32'h0, 32'h3008, 1'b0);
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("jal.tgt", 32'h3044, 32'hC0DE_3040, 32'h3040, 1'b0);

        // j at 0x3040 -> 0x3010 to set up the branch.
        drive(1'b1, 2'd0, 26'h000_0C04, 16'd0, 32'd0);
        tick(); expect_state("j", 32'h3010, 32'hC0DE_3044, 32'h3044, 1'b0);
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("j.tgt", 32'h3014, 32'hC0DE_3010, 32'h3010, 1'b0);

        // beq at 0x3010, offset -4 words -> 0x3004.
        drive(1'b1, 2'd1, 26'd0, 16'hFFFC, 32'd0);
        tick(); expect_state("beq", 32'h3004, 32'hC0DE_3014, 32'h3014, 1'b0);
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("beq.tgt", 32'h3008, 32'h3403_0002, 32'h3004, 1'b0);

        // Stall two cycles with a pending jal; taken once on release.
        stall = 1'b1;
        drive(1'b1, 2'd0, 26'h000_0C10, 16'd0, 32'd0);
        tick(); expect_state("stall1", 32'h3008, 32'h3403_0002, 32'h3004, 1'b0);
        tick(); expect_state("stall2", 32'h3008, 32'h3403_0002, 32'h3004, 1'b0);
        stall = 1'b0;
        tick(); expect_state("unstall", 32'h3040, 32'h0, 32'h3008, 1'b0);
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("unstall.once", 32'h3044, 32'hC0DE_3040, 32'h3040, 1'b0);

        // jr below the window.
        drive(1'b1, 2'd2, 26'd0, 16'd0, 32'h0000_1000);
        tick(); expect_state("jr.low", 32'h1000, 32'hC0DE_3044, 32'h3044, 1'b0);
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("jr.low.f", 32'h1004, 32'h0, 32'h1000, 1'b1);
        drive(1'b1, 2'd2, 26'd0, 16'd0, 32'h0000_3000);
        tick(); expect_state("jr.back", 32'h3000, 32'h0, 32'h1004, 1'b1);
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("sticky", 32'h3004, 32'h3402_0001, 32'h3000, 1'b1);

        // Asynchronous reset mid-cycle during a redirect.
        drive(1'b1, 2'd0, 26'h000_0C10, 16'd0, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        expect_state("arst", 32'h3000, 32'h0, 32'h3000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 2'd0, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("arst.run", 32'h3004, 32'h3402_0001, 32'h3000, 1'b0);

        // Misaligned jr target.
        drive(1'b1, 2'd2, 26'd0, 16'd0, 32'h0000_3002);
        tick(); expect_state("jr.mis", 32'h3002, 32'h3403_0002, 32'h3004, 1'b0);
        drive(1'b1, 2'd3, 26'd0, 16'd0, 32'd0);
        tick(); expect_state("jr.mis.f", 32'h3006, 32'h0, 32'h3002, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
